fifo_stream_reader: RTL and testbench
=====================================

FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

Interface
REQ-001 SHALL have parameter DATA_BITS, default 64: width of FIFO data and stream tdata.
REQ-002 SHALL have parameter LEN_BITS, default 16: width of the packet-length input and beat counter.
REQ-003 SHALL have port aclk, input, 1: single clock; all logic is on the rising edge.
REQ-004 SHALL have port aresetn, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port fifo_ready_rd, input, 1: the upstream show-ahead FIFO holds at least one word.
REQ-006 SHALL have port fifo_data_out, input, DATA_BITS: the FIFO head word, valid while fifo_ready_rd is high.
REQ-007 SHALL have port fifo_rd, output, 1: pops the FIFO head at the rising edge.
REQ-008 SHALL have port pkt_len, input, LEN_BITS: beats per packet, sampled on each packet's first pop.
REQ-009 SHALL have port m_axis_tvalid, output, 1: AXI4-Stream valid.
REQ-010 SHALL have port m_axis_tready, input, 1: AXI4-Stream ready.
REQ-011 SHALL have port m_axis_tdata, output, DATA_BITS: AXI4-Stream data.
REQ-012 SHALL have port m_axis_tlast, output, 1: AXI4-Stream last beat of packet.
REQ-013 SHALL have port idle, output, 1: high when the buffer is empty and the beat counter is 0.

Function
REQ-014 SHALL hold popped words in an internal 2-entry buffer; each entry is {tlast, data}; occupancy is 0, 1 or 2.
REQ-015 SHALL drive fifo_rd = fifo_ready_rd AND (occupancy < 2), using registered occupancy only; there is no combinational path from m_axis_tready to fifo_rd.
REQ-016 SHALL capture fifo_data_out into the buffer tail on every cycle where fifo_rd is high.
REQ-017 SHALL drive m_axis_tvalid = (occupancy != 0), with tdata/tlast taken from the buffer head.
REQ-018 SHALL complete a transfer when m_axis_tvalid AND m_axis_tready; the head retires and the second entry, if any, becomes head on the same edge.
REQ-019 SHALL update occupancy as follows: pop without transfer gives +1; transfer without pop gives -1; pop and transfer together leave it unchanged.
REQ-020 SHALL keep tdata/tlast stable while tvalid is high and tready is low.
REQ-021 SHALL have a latency of one cycle: a word popped at edge N appears with tvalid high after edge N, when the buffer was empty.
REQ-022 SHALL sustain one beat per cycle when tready is held high and the FIFO is never empty.
REQ-023 SHALL maintain beat_idx (LEN_BITS) and len_q (LEN_BITS), advanced only on pops.
REQ-024 SHALL latch len_q from pkt_len on a pop with beat_idx == 0; a pkt_len of 0 SHALL be treated as 1.
REQ-025 SHALL set the stored tlast for a popped word when beat_idx == effective_len-1; beat_idx then returns to 0, otherwise it increments. effective_len is pkt_len on the first beat and len_q afterwards.
REQ-026 SHALL tag every beat with tlast=1 when effective_len == 1.
REQ-027 SHALL leave packets in progress unaffected by pkt_len changes made mid-packet.
REQ-028 SHALL, when fifo_ready_rd is low, neither pop nor change beat_idx; the buffer drains normally.
REQ-029 SHALL drive idle = (occupancy == 0) AND (beat_idx == 0).

Reset
REQ-030 SHALL, on aresetn low, immediately clear occupancy, the buffer pointers, beat_idx and len_q to 0.
REQ-031 SHALL hold these outputs during reset: m_axis_tvalid=0, fifo_rd=0, m_axis_tlast=0, m_axis_tdata=0, idle=1.
REQ-032 SHALL, on reset mid-packet, drop the partial packet; the first pop after release starts a new packet.
REQ-033 SHALL deassert reset synchronously to aclk; the synchronizer is upstream of this block.

Structure
REQ-034 SHALL import default widths (DATA_BITS 64, LEN_BITS 16) from roceTypes; no new typedefs are required.
REQ-035 SHALL implement the 2-entry buffer inline (asynchronous reset required); no sub-module.

Verification
REQ-036 SHALL cover streaming: pkt_len=4, 8 words queued, tready=1 -> 8 consecutive beats, tlast on beats 4 and 8, first tvalid one cycle after the first fifo_rd.
REQ-037 SHALL cover backpressure: tready=0 for 5 cycles with the FIFO non-empty -> exactly 2 pops, then fifo_rd=0; tdata stable; no loss or reorder after tready=1.
REQ-038 SHALL cover length edge cases: pkt_len=0 and pkt_len=1 -> tlast=1 on every beat.
REQ-039 SHALL cover a mid-packet length change: pkt_len changed 3->5 after beat 1 -> the current packet ends at beat 3, the next packet is 5 beats.
REQ-040 SHALL cover counter wrap: pkt_len=16'hFFFF -> tlast on beat 65535 only, beat_idx returns to 0.
REQ-041 SHALL cover reset mid-operation: aresetn asserted with occupancy 2 and beat_idx 2 -> tvalid=0 and idle=1 immediately, and the next packet starts at beat_idx 0.

Source files
------------

// File: rtl/roceTypes.sv
// Shared RoCE datapath widths; blocks take their parameter defaults from here.
package roceTypes;

    localparam int ROCE_DATA_BITS = 64;
    localparam int ROCE_LEN_BITS  = 16;

endpackage

// File: rtl/fifo_stream_reader.sv
// Drains a show-ahead FIFO into an AXI4-Stream master through a 2-entry skid buffer,
// framing packets of pkt_len beats with tlast.
module fifo_stream_reader
    import roceTypes::*;
#(
    parameter int DATA_BITS = ROCE_DATA_BITS,
    parameter int LEN_BITS  = ROCE_LEN_BITS
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 fifo_ready_rd,
    input  logic [DATA_BITS-1:0] fifo_data_out,
    output logic                 fifo_rd,
    input  logic [LEN_BITS-1:0]  pkt_len,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic [DATA_BITS-1:0] m_axis_tdata,
    output logic                 m_axis_tlast,
    output logic                 idle
);

    localparam logic [LEN_BITS-1:0] LenOne = LEN_BITS'(1);

    logic [DATA_BITS:0]  buf_q [2];
    logic                rdPtr_q, rdPtr_d;
    logic                wrPtr_q, wrPtr_d;
    logic [1:0]          occ_q, occ_d;
    logic [LEN_BITS-1:0] beatIdx_q, beatIdx_d;
    logic [LEN_BITS-1:0] len_q, len_d;

    logic                pop;
    logic                xfer;
    logic                popLast;
    logic [LEN_BITS-1:0] pktLenNorm;
    logic [LEN_BITS-1:0] effLen;

    // Pop decision uses registered occupancy only, so tready never reaches fifo_rd.
    always_comb begin
        pop        = aresetn & fifo_ready_rd & (occ_q != 2'd2);
        xfer       = (occ_q != 2'd0) & m_axis_tready;
        pktLenNorm = (pkt_len == '0) ? LenOne : pkt_len;
        effLen     = (beatIdx_q == '0) ? pktLenNorm : len_q;
        popLast    = (beatIdx_q == (effLen - LenOne));

        occ_d     = occ_q;
        rdPtr_d   = rdPtr_q;
        wrPtr_d   = wrPtr_q;
        beatIdx_d = beatIdx_q;
        len_d     = len_q;

        if (pop && !xfer) begin
            occ_d = occ_q + 2'd1;
        end else if (xfer && !pop) begin
            occ_d = occ_q - 2'd1;
        end

        if (pop) begin
            wrPtr_d = ~wrPtr_q;
            if (beatIdx_q == '0) begin
                len_d = pktLenNorm;
            end
            beatIdx_d = popLast ? '0 : beatIdx_q + LenOne;
        end

        if (xfer) begin
            rdPtr_d = ~rdPtr_q;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            occ_q     <= 2'd0;
            rdPtr_q   <= 1'b0;
            wrPtr_q   <= 1'b0;
            beatIdx_q <= '0;
            len_q     <= '0;
            buf_q[0]  <= '0;
            buf_q[1]  <= '0;
        end else begin
            occ_q     <= occ_d;
            rdPtr_q   <= rdPtr_d;
            wrPtr_q   <= wrPtr_d;
            beatIdx_q <= beatIdx_d;
            len_q     <= len_d;
            if (pop) begin
                buf_q[wrPtr_q] <= {popLast, fifo_data_out};
            end
        end
    end

    always_comb begin
        fifo_rd       = pop;
        m_axis_tvalid = (occ_q != 2'd0);
        m_axis_tlast  = buf_q[rdPtr_q][DATA_BITS];
        m_axis_tdata  = buf_q[rdPtr_q][DATA_BITS-1:0];
        idle          = (occ_q == 2'd0) && (beatIdx_q == '0);
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Randomized bench for fifo_stream_reader: a queue-based source FIFO and a packet-position
// reference model predict every pop, beat and tlast.
module tb_fifo_stream_reader;

    localparam int DW = 64;
    localparam int LW = 16;

    logic          aclk = 1'b0;
    logic          aresetn;
    logic          fifo_ready_rd;
    logic [DW-1:0] fifo_data_out;
    logic          fifo_rd;
    logic [LW-1:0] pkt_len;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tlast;
    logic          idle;

    always #5 aclk = ~aclk;

    fifo_stream_reader #(.DATA_BITS(DW), .LEN_BITS(LW)) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .fifo_ready_rd(fifo_ready_rd),
        .fifo_data_out(fifo_data_out),
        .fifo_rd      (fifo_rd),
        .pkt_len      (pkt_len),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tlast (m_axis_tlast),
        .idle         (idle)
    );

    int assertCount = 0;
    int failCount   = 0;

    // Reference model: words waiting upstream, {tlast,data} words held by the DUT,
    // and the position inside the packet currently being popped.
    logic [DW-1:0] srcQ [$];
    logic [DW:0]   outQ [$];
    int            pos    = 0;
    int            curLen = 1;

    int cycleNum = 0;
    int popCnt, beatCnt, tlastCnt, firstTlastBeat, lastTlastBeat;
    int firstRdCycle, firstValidCycle, firstXferCycle, lastXferCycle;

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic resetStats();
        popCnt          = 0;
        beatCnt         = 0;
        tlastCnt        = 0;
        firstTlastBeat  = -1;
        lastTlastBeat   = -1;
        firstRdCycle    = -1;
        firstValidCycle = -1;
        firstXferCycle  = -1;
        lastXferCycle   = -1;
    endtask

    task automatic pushWords(input int n);
        for (int i = 0; i < n; i++) srcQ.push_back({$urandom, $urandom});
    endtask

    // One clock: drive inputs at the falling edge, check outputs against the model,
    // then advance the model to what the next rising edge must do.
    task automatic applyStimulus(input bit srcEn, input bit ready, input logic [LW-1:0] len);
        bit          expRd;
        bit          expValid;
        logic [DW:0] head;
        @(negedge aclk);
        cycleNum++;
        fifo_ready_rd = srcEn && (srcQ.size() > 0);
        fifo_data_out = (srcQ.size() > 0) ? srcQ[0] : {$urandom, $urandom};
        m_axis_tready = ready;
        pkt_len       = len;
        #1;
        expRd    = fifo_ready_rd && (outQ.size() < 2);
        expValid = (outQ.size() != 0);
        checkOutput("fifo_rd", fifo_rd, expRd);
        checkOutput("tvalid", m_axis_tvalid, expValid);
        checkOutput("idle", idle, (outQ.size() == 0) && (pos == 0));
        if (expValid) begin
            head = outQ[0];
            checkOutput("tdata", m_axis_tdata, head[DW-1:0]);
            checkOutput("tlast", m_axis_tlast, head[DW]);
        end

        if (fifo_rd) begin
            popCnt++;
            if (firstRdCycle < 0) firstRdCycle = cycleNum;
        end
        if (m_axis_tvalid && firstValidCycle < 0) firstValidCycle = cycleNum;
        if (m_axis_tvalid && ready) begin
            beatCnt++;
            if (firstXferCycle < 0) firstXferCycle = cycleNum;
            lastXferCycle = cycleNum;
            if (m_axis_tlast) begin
                tlastCnt++;
                lastTlastBeat = beatCnt;
                if (firstTlastBeat < 0) firstTlastBeat = beatCnt;
            end
        end

        if (expValid && ready) void'(outQ.pop_front());
        if (expRd) begin
            if (pos == 0) curLen = (len == 0) ? 1 : int'(len);
            pos++;
            outQ.push_back({pos == curLen, srcQ.pop_front()});
            if (pos == curLen) pos = 0;
        end
    endtask

    task automatic drain(input logic [LW-1:0] len);
        int n = 0;
        while ((srcQ.size() != 0 || outQ.size() != 0) && n < 500) begin
            applyStimulus(1'b1, 1'b1, len);
            n++;
        end
        checkOutput("drainBudget", n < 500, 1'b1);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear before any clock edge.
    task automatic doReset();
        @(posedge aclk);
        #2;
        aresetn = 1'b0;
        #1;
        checkOutput("rstValid", m_axis_tvalid, 1'b0);
        checkOutput("rstIdle", idle, 1'b1);
        checkOutput("rstRd", fifo_rd, 1'b0);
        checkOutput("rstLast", m_axis_tlast, 1'b0);
        checkOutput("rstData", m_axis_tdata, '0);
        outQ.delete();
        pos           = 0;
        fifo_ready_rd = 1'b0;
        m_axis_tready = 1'b0;
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
    endtask

    initial begin
        int          n;
        logic [LW-1:0] curPkt;
        aresetn       = 1'b0;
        fifo_ready_rd = 1'b1;
        fifo_data_out = {$urandom, $urandom};
        pkt_len       = 16'd4;
        m_axis_tready = 1'b1;
        resetStats();

        #1;
        checkOutput("initValid", m_axis_tvalid, 1'b0);
        checkOutput("initRd", fifo_rd, 1'b0);
        checkOutput("initLast", m_axis_tlast, 1'b0);
        checkOutput("initData", m_axis_tdata, '0);
        checkOutput("initIdle", idle, 1'b1);
        fifo_ready_rd = 1'b0;
        m_axis_tready = 1'b0;
        repeat (3) @(negedge aclk);
        aresetn = 1'b1;

        // Full-rate streaming of two 4-beat packets.
        $display("[TB] streaming");
        resetStats();
        pushWords(8);
        for (int i = 0; i < 12; i++) applyStimulus(1'b1, 1'b1, 16'd4);
        checkOutput("streamBeats", beatCnt, 8);
        checkOutput("streamTlastCnt", tlastCnt, 2);
        checkOutput("streamFirstTlast", firstTlastBeat, 4);
        checkOutput("streamLastTlast", lastTlastBeat, 8);
        checkOutput("streamLatency", firstValidCycle - firstRdCycle, 1);
        checkOutput("streamSpan", lastXferCycle - firstXferCycle, 7);

        // Backpressure: the buffer absorbs exactly two words, then stalls the FIFO.
        $display("[TB] backpressure");
        resetStats();
        pushWords(6);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 16'd3);
        checkOutput("bpPops", popCnt, 2);
        drain(16'd3);
        checkOutput("bpBeats", beatCnt, 6);
        checkOutput("bpTlastCnt", tlastCnt, 2);

        // Lengths 0 and 1 both mean single-beat packets.
        for (int l = 0; l < 2; l++) begin
            $display("[TB] pkt_len %0d", l);
            resetStats();
            pushWords(10);
            for (int i = 0; i < 30; i++)
                applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0, LW'(l));
            drain(LW'(l));
            checkOutput("shortBeats", beatCnt, 10);
            checkOutput("shortTlastAll", tlastCnt, beatCnt);
        end

        // pkt_len changes 3->5 after the first pop; the open packet keeps length 3.
        $display("[TB] mid-packet length change");
        resetStats();
        pushWords(8);
        curPkt = 16'd3;
        for (int i = 0; i < 14; i++) begin
            applyStimulus(1'b1, 1'b1, curPkt);
            if (popCnt >= 1) curPkt = 16'd5;
        end
        checkOutput("chgBeats", beatCnt, 8);
        checkOutput("chgFirstTlast", firstTlastBeat, 3);
        checkOutput("chgLastTlast", lastTlastBeat, 8);
        checkOutput("chgTlastCnt", tlastCnt, 2);

        // Maximum length exercises the full counter range.
        $display("[TB] counter wrap");
        resetStats();
        pushWords(65535);
        n = 0;
        while (beatCnt < 65535 && n < 65600) begin
            applyStimulus(1'b1, 1'b1, 16'hFFFF);
            n++;
        end
        applyStimulus(1'b0, 1'b1, 16'hFFFF);
        checkOutput("wrapBeats", beatCnt, 65535);
        checkOutput("wrapTlastCnt", tlastCnt, 1);
        checkOutput("wrapTlastBeat", lastTlastBeat, 65535);
        checkOutput("wrapIdle", idle, 1'b1);

        // Random traffic with random lengths and backpressure.
        $display("[TB] random traffic");
        resetStats();
        pushWords(40);
        for (int i = 0; i < 120; i++)
            applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                          LW'($urandom_range(0, 4)));
        drain(16'd2);
        doReset();

        // Reset with two words buffered and beat index 2, then restart cleanly.
        $display("[TB] reset mid-packet");
        resetStats();
        pushWords(6);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 16'd8);
        checkOutput("preRstPops", popCnt, 2);
        doReset();
        resetStats();
        drain(16'd2);
        checkOutput("postRstBeats", beatCnt, 4);
        checkOutput("postRstFirstTlast", firstTlastBeat, 2);
        checkOutput("postRstTlastCnt", tlastCnt, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
